// File: rtl/y_serial_subtractor.sv
// Bit-serial two's-complement subtractor: z = a - b - bin, one result bit per clock, LSB first.
// Start/done handshake; results and flags hold from done until the next accepted start.
module y_serial_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [WIDTH-1:0] z_q,      z_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             borrow_q, borrow_d;
  logic             bout_q,   bout_d;
  logic             ovf_q,    ovf_d;
  logic             zero_q,   zero_d;

  logic a_bit;
  logic b_bit;

  assign a_bit = a_q[cnt_q];
  assign b_bit = b_q[cnt_q];

  // NOTE: every variable gets its hold value first so no path through the
  // case statement leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    z_d      = z_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = '0;
          z_d      = '0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      RUN: begin
        z_d[cnt_q] = a_bit ^ b_bit ^ borrow_q;
        borrow_d   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_q);
        if (cnt_q == LAST) begin
          // Final bit: flags are derived from the completed difference.
          state_d = DONE;
          cnt_d   = '0;
          bout_d  = borrow_d;
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (z_d[WIDTH-1] != a_q[WIDTH-1]);
          zero_d  = (z_d == '0);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      z_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      z_q      <= z_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign z    = z_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_y_serial_subtractor.sv
// Self-checking bench for y_serial_subtractor: directed corner cases, handshake
// timing, mid-run reset, then randomized operations against an arithmetic model.
module tb_y_serial_subtractor;

  localparam int W = 32;

  logic         clk;
  logic         resetn;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] z;
  logic         bout;
  logic         ovf;
  logic         zero;

  y_serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .a      (a),
    .b      (b),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .z      (z),
    .bout   (bout),
    .ovf    (ovf),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Last expected result, used to confirm outputs hold while idle.
  logic [W-1:0] hold_z;
  logic         hold_bout;
  logic         hold_ovf;
  logic         hold_zero;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: signed/unsigned arithmetic on wide integers.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                       output logic [W-1:0] ez, output logic eb, output logic eo);
    longint ua, ub, sa, sb, sd;
    ua = longint'({32'b0, ma});
    ub = longint'({32'b0, mb});
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    sd = sa - sb - longint'(mbin);
    ez = W'(ua - ub - longint'(mbin));
    eb = (ua < ub + longint'(mbin));
    eo = (sd > (64'sd1 <<< (W - 1)) - 1) || (sd < -(64'sd1 <<< (W - 1)));
  endtask

  // Called at a negedge; issues start and follows the operation to done.
  // intrude_at > 0 pulses a spurious start with fresh operands mid-run.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                       input int intrude_at);
    logic [W-1:0] ez;
    logic         eb, eo;
    int           cycles;
    bit           got_done;
    model(oa, ob, obin, ez, eb, eo);
    a      = oa;
    b      = ob;
    bin    = obin;
    start  = 1'b1;
    cycles = 0;
    got_done = 1'b0;
    while (!got_done && cycles < 3 * W) begin
      @(negedge clk);
      cycles++;
      start = (cycles == intrude_at);
      a     = $urandom;
      b     = $urandom;
      bin   = 1'($urandom);
      if (cycles == 1) begin
        check("busy_after_accept", 64'(busy), 64'd1);
        check("done_after_accept", 64'(done), 64'd0);
      end
      if (done) got_done = 1'b1;
    end
    start = 1'b0;
    check("latency", 64'(cycles), 64'(W + 1));
    check("z", 64'(z), 64'(ez));
    check("bout", 64'(bout), 64'(eb));
    check("ovf", 64'(ovf), 64'(eo));
    check("zero", 64'(zero), 64'(ez == '0));
    check("busy_at_done", 64'(busy), 64'd0);
    hold_z    = ez;
    hold_bout = eb;
    hold_ovf  = eo;
    hold_zero = (ez == '0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_done", 64'(done), 64'd0);
      check("hold_z", 64'(z), 64'(hold_z));
      check("hold_flags", {61'b0, bout, ovf, zero}, {61'b0, hold_bout, hold_ovf, hold_zero});
    end
  endtask

  initial begin
    int done_seen;
    resetn = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    bin    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {27'b0, busy, done, z, bout, ovf, zero}, 64'd0);
    resetn = 1'b1;
    hold_z = '0; hold_bout = 1'b0; hold_ovf = 1'b0; hold_zero = 1'b0;
    idle(1);

    // Directed corner cases.
    do_op(32'd10, 32'd3, 1'b0, 0);                  idle(2);
    do_op(32'd3, 32'd10, 1'b0, 0);                  idle(1);
    do_op(32'h8000_0000, 32'd1, 1'b0, 0);           idle(1);
    do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);   idle(1);
    do_op(32'd5, 32'd4, 1'b1, 0);                   idle(1);
    do_op(32'd0, 32'd0, 1'b1, 0);                   idle(1);

    // Spurious start mid-run, then back-to-back start in the DONE cycle.
    do_op(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 5);
    do_op(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 0);
    idle(2);

    // Reset during a run aborts it with no done.
    a = 32'd0; b = 32'd7; bin = 1'b1; start = 1'b1;
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_outputs", {27'b0, busy, done, z, bout, ovf, zero}, 64'd0);
    resetn = 1'b1;
    done_seen = 0;
    repeat (W + 5) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("midrst_no_done", 64'(done_seen), 64'd0);
    hold_z = '0; hold_bout = 1'b0; hold_ovf = 1'b0; hold_zero = 1'b0;
    idle(1);

    // Randomized operations with occasional intrusions and idle gaps.
    for (int i = 0; i < 500; i++) begin
      logic [W-1:0] ra, rb;
      int           intr;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = ra;
        1: ra = '0;
        2: rb = '1;
        default: ;
      endcase
      intr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, W)) : 0;
      do_op(ra, rb, 1'($urandom), intr);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
